writeback: RTL and testbench

// - Final pipeline stage; consumes the execute-stage register outputs (data, instr, abs operand, 7-bit flags, reset request).
// - Commits results to the register-file write port and holds the architectural status-flag register.
// - For absolute-register ops (opcode 13..17), runs a multi-cycle register-clear sweep and back-pressures upstream while the sweep runs.

---
 rtl/writeback.sv | 188 ++++++++++++++++++
 tb/tb_writeback.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
`default_nettype none
// ============================================================================
//  Module      : writeback
//  Description : Final pipeline stage. Commits execute-stage results to the
//                register-file write port, holds the architectural flag
//                register and runs a register-clear sweep after
//                absolute-register ops, stalling upstream while it runs.
//                Optional feature macro: WB_STICKY_ERROR_EN (sticky error
//                flag cleared by flag_clr).
//  Revision    : 1.0  initial release
// ============================================================================
module writeback #(
    parameter int DWIDTH   = 32,
    parameter int NREGS    = 32,
    parameter int CLR_BASE = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ex_valid,
    input  logic [DWIDTH-1:0]         ex_data,
    input  logic [DWIDTH-1:0]         ex_instr,
    input  logic [DWIDTH-1:0]         ex_abs,
    input  logic [6:0]                ex_flags,
    input  logic                      ex_reset_regs,
    input  logic                      flag_clr,
    output logic                      wb_stall,
    output logic                      rf_we,
    output logic [$clog2(NREGS)-1:0]  rf_waddr,
    output logic [DWIDTH-1:0]         rf_wdata,
    output logic [6:0]                flags_q,
    output logic                      err_irq
);

    localparam int c_AWIDTH = $clog2(NREGS);
    // A sweep is only possible when the first cleared index is a real register.
    localparam bit c_SWEEP_EN = (CLR_BASE < NREGS);
    localparam logic [c_AWIDTH-1:0] c_CLR_BASE = c_SWEEP_EN ? c_AWIDTH'(CLR_BASE) : '0;
    localparam logic [c_AWIDTH-1:0] c_LAST_IDX = c_AWIDTH'(NREGS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SWEEP = 1'b1
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [c_AWIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [c_AWIDTH-1:0]   r_skip, w_skip_nxt;
    logic                  r_err_d;

    logic                  w_stall_nxt;
    logic                  w_we_nxt;
    logic [c_AWIDTH-1:0]   w_waddr_nxt;
    logic [DWIDTH-1:0]     w_wdata_nxt;
    logic [6:0]            w_flags_nxt;

    logic [4:0]            w_opcode;
    logic [4:0]            w_rd;
    logic [c_AWIDTH-1:0]   w_rd_a;
    logic                  w_accept;
    logic                  w_is_alu;
    logic                  w_is_abs;
    logic                  w_nonnop;
    logic                  w_unused;

    assign w_opcode = ex_instr[DWIDTH-1 -: 5];
    assign w_rd     = ex_instr[DWIDTH-6 -: 5];
    assign w_rd_a   = c_AWIDTH'(w_rd);
    assign w_accept = ex_valid && !wb_stall && (r_state == S_IDLE);
    assign w_nonnop = (w_opcode != 5'd0);
    assign w_is_alu = (w_opcode >= 5'd1)  && (w_opcode <= 5'd12);
    assign w_is_abs = (w_opcode >= 5'd13) && (w_opcode <= 5'd17);

`ifdef WB_STICKY_ERROR_EN
    assign w_unused = ^ex_instr[DWIDTH-11:0];
`else
    assign w_unused = (^ex_instr[DWIDTH-11:0]) ^ flag_clr;
`endif

    // Next-state and next-output decode: commit in IDLE, one clear per cycle in SWEEP.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_skip_nxt  = r_skip;
        w_stall_nxt = 1'b0;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = rf_waddr;
        w_wdata_nxt = rf_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_alu) begin
                        w_we_nxt    = (w_rd != 5'd0);
                        w_waddr_nxt = w_rd_a;
                        w_wdata_nxt = ex_data;
                    end else if (w_is_abs) begin
                        w_we_nxt    = (w_rd != 5'd0);
                        w_waddr_nxt = w_rd_a;
                        w_wdata_nxt = ex_abs;
                        if (ex_reset_regs && c_SWEEP_EN) begin
                            w_state_nxt = S_SWEEP;
                            w_cnt_nxt   = c_CLR_BASE;
                            w_skip_nxt  = w_rd_a;
                            w_stall_nxt = 1'b1;
                        end
                    end
                end
            end
            S_SWEEP: begin
                w_waddr_nxt = r_cnt;
                w_wdata_nxt = '0;
                // The just-written destination and r0 are never cleared.
                w_we_nxt    = (r_cnt != r_skip) && (r_cnt != '0);
                if (r_cnt == c_LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                    w_stall_nxt = 1'b0;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_stall_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Flag register update; flags are frozen while a sweep runs.
    always_comb begin
        w_flags_nxt = flags_q;
        if (w_accept && w_nonnop) begin
            w_flags_nxt[5:0] = ex_flags[5:0];
        end
`ifdef WB_STICKY_ERROR_EN
        if (w_accept && w_nonnop && ex_flags[6]) begin
            w_flags_nxt[6] = 1'b1;
        end else if (flag_clr && (r_state == S_IDLE)) begin
            w_flags_nxt[6] = 1'b0;
        end
`else
        if (w_accept && w_nonnop) begin
            w_flags_nxt[6] = ex_flags[6];
        end
`endif
    end

    // FSM state, sweep counter and skip index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_skip  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_skip  <= w_skip_nxt;
        end
    end

    // Registered write port, stall and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_stall <= 1'b0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            flags_q  <= '0;
        end else begin
            wb_stall <= w_stall_nxt;
            rf_we    <= w_we_nxt;
            rf_waddr <= w_waddr_nxt;
            rf_wdata <= w_wdata_nxt;
            flags_q  <= w_flags_nxt;
        end
    end

    // Rising-edge detect on the error flag, one cycle wide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_d <= 1'b0;
            err_irq <= 1'b0;
        end else begin
            r_err_d <= flags_q[6];
            err_irq <= flags_q[6] & ~r_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_writeback.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback
//  Description : Self-checking bench for writeback. Directed scenarios plus
//                randomized traffic against a queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_writeback;

    localparam int NREGS    = 32;
    localparam int CLR_BASE = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_reset_regs, flag_clr;
    logic [31:0] ex_data, ex_instr, ex_abs;
    logic [6:0]  ex_flags;

    logic        wb_stall, rf_we, err_irq;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [6:0]  flags_q;

    logic        n_wb_stall, n_rf_we, n_err_irq;
    logic [4:0]  n_rf_waddr;
    logic [31:0] n_rf_wdata;
    logic [6:0]  n_flags_q;

    always #5 clk = ~clk;

    writeback #(.DWIDTH(32), .NREGS(NREGS), .CLR_BASE(CLR_BASE)) u_dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_data(ex_data),
        .ex_instr(ex_instr), .ex_abs(ex_abs), .ex_flags(ex_flags),
        .ex_reset_regs(ex_reset_regs), .flag_clr(flag_clr),
        .wb_stall(wb_stall), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .flags_q(flags_q), .err_irq(err_irq)
    );

    // Second instance whose clear base is out of range: it must never sweep.
    writeback #(.DWIDTH(32), .NREGS(NREGS), .CLR_BASE(32)) u_dut_nosweep (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_data(ex_data),
        .ex_instr(ex_instr), .ex_abs(ex_abs), .ex_flags(ex_flags),
        .ex_reset_regs(ex_reset_regs), .flag_clr(flag_clr),
        .wb_stall(n_wb_stall), .rf_we(n_rf_we), .rf_waddr(n_rf_waddr),
        .rf_wdata(n_rf_wdata), .flags_q(n_flags_q), .err_irq(n_err_irq)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        we;
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         pend[$];      // writes the sweep still owes, one per cycle
    logic        m_we, m_stall, m_err, m_f6_d, m_acc;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [6:0]  m_flags;

    task automatic model_reset();
        pend.delete();
        m_we = 0; m_stall = 0; m_err = 0; m_f6_d = 0; m_acc = 0;
        m_waddr = 0; m_wdata = 0; m_flags = 0;
    endtask

    task automatic model_edge();
        logic [4:0] op, rd;
        wr_t        e;
        op = ex_instr[31:27];
        rd = ex_instr[26:22];
        m_err  = m_flags[6] & ~m_f6_d;
        m_f6_d = m_flags[6];
        m_we   = 1'b0;
        m_acc  = 1'b0;
        if (pend.size() > 0) begin
            e = pend.pop_front();
            m_we = e.we; m_waddr = e.addr; m_wdata = e.data;
        end else begin
            m_acc = ex_valid;
            if (ex_valid && op != 0) begin
                m_flags[5:0] = ex_flags[5:0];
`ifndef WB_STICKY_ERROR_EN
                m_flags[6] = ex_flags[6];
`endif
            end
`ifdef WB_STICKY_ERROR_EN
            if (ex_valid && op != 0 && ex_flags[6]) m_flags[6] = 1'b1;
            else if (flag_clr)                      m_flags[6] = 1'b0;
`endif
            if (ex_valid && op >= 1 && op <= 17) begin
                m_we    = (rd != 0);
                m_waddr = rd;
                m_wdata = (op <= 12) ? ex_data : ex_abs;
                if (op >= 13 && ex_reset_regs) begin
                    for (int r = CLR_BASE; r < NREGS; r++) begin
                        e.we   = (r != int'(rd)) && (r != 0);
                        e.addr = r[4:0];
                        e.data = 32'h0;
                        pend.push_back(e);
                    end
                end
            end
        end
        m_stall = (pend.size() > 0);
    endtask

    task automatic cmp_all();
        check("stall", wb_stall, m_stall);
        check("we", rf_we, m_we);
        if (m_we) begin
            check("waddr", rf_waddr, m_waddr);
            check("wdata", rf_wdata, m_wdata);
        end
        check("flags", flags_q, m_flags);
        check("err_irq", err_irq, m_err);
    endtask

    // One clock: model follows the edge, DUT is sampled on the falling edge.
    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_edge();
        else       model_reset();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [4:0] rd,
                         input logic [31:0] d, input logic [31:0] a, input logic [6:0] f,
                         input logic rr, input logic clr);
        ex_valid      = v;
        ex_instr      = {op, rd, 22'($urandom)};
        ex_data       = d;
        ex_abs        = a;
        ex_flags      = f;
        ex_reset_regs = rr;
        flag_clr      = clr;
    endtask

    task automatic drive_random();
        int cls;
        logic [4:0] op;
        cls = $urandom_range(0, 9);
        if (cls == 0)      op = 5'd0;
        else if (cls <= 4) op = 5'($urandom_range(1, 12));
        else if (cls <= 5) op = 5'($urandom_range(13, 17));
        else               op = 5'($urandom_range(18, 31));
        drive(($urandom_range(0, 4) != 0), op, 5'($urandom), $urandom, $urandom,
              7'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check({tag, "_stall"}, wb_stall, 1'b0);
        check({tag, "_we"}, rf_we, 1'b0);
        check({tag, "_waddr"}, rf_waddr, 5'd0);
        check({tag, "_wdata"}, rf_wdata, 32'd0);
        check({tag, "_flags"}, flags_q, 7'd0);
        check({tag, "_err"}, err_irq, 1'b0);
    endtask

    initial begin
        int cnt;
        rst_n = 1'b0;
        model_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        cycle(); cycle();
        async_reset_check("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ALU write.
        drive(1, 5'd1, 5'd5, 32'hDEADBEEF, 32'h0, 7'h01, 0, 0);
        cycle();
        check("alu_we", rf_we, 1'b1);
        check("alu_waddr", rf_waddr, 5'd5);
        check("alu_wdata", rf_wdata, 32'hDEADBEEF);

        // rd==0 suppression, then NOP leaves flags alone.
        drive(1, 5'd3, 5'd0, 32'h55, 32'h0, 7'h04, 0, 0);
        cycle();
        check("rd0_we", rf_we, 1'b0);
        check("rd0_flags", flags_q, 7'h04);
        drive(1, 5'd0, 5'd9, 32'h66, 32'h0, 7'h7F, 0, 0);
        cycle();
        check("nop_flags", flags_q, 7'h04);

        // Sweep with an instruction held during the stall.
        drive(1, 5'd14, 5'd20, 32'h0, 32'h1234, 7'h02, 1, 0);
        cycle();
        check("abs_we", rf_we, 1'b1);
        check("abs_waddr", rf_waddr, 5'd20);
        check("abs_wdata", rf_wdata, 32'h1234);
        drive(1, 5'd2, 5'd7, 32'hCAFE, 32'h0, 7'h08, 0, 0);
        cnt = 0;
        for (int k = 1; k <= 16; k++) begin
            if (wb_stall) cnt++;
            cycle();
        end
        check("sweep_stall_len", cnt, 16);
        check("sweep_last_addr", rf_waddr, 5'd31);
        check("sweep_last_stall", wb_stall, 1'b0);
        cycle();
        check("held_waddr", rf_waddr, 5'd7);
        check("held_wdata", rf_wdata, 32'hCAFE);
        check("held_flags", flags_q, 7'h08);

        // Reset in the middle of a sweep.
        drive(1, 5'd15, 5'd3, 32'h0, 32'hABCD, 7'h00, 1, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (!(m_we && m_waddr == 5'd21) && cnt < 30) begin
            cycle();
            cnt++;
        end
        check("midsweep_reached", (cnt < 30), 1'b1);
        async_reset_check("midsweep");
        cycle(); cycle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle();
        check("post_reset_we", rf_we, 1'b0);

        // Error flag and interrupt pulse.
        drive(1, 5'd20, 5'd1, 32'h0, 32'h0, 7'h40, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            cycle();
            cnt += int'(err_irq);
        end
        check("err_pulse_count", cnt, 1);
        drive(1, 5'd20, 5'd1, 32'h0, 32'h0, 7'h00, 0, 0);
        cycle();
`ifdef WB_STICKY_ERROR_EN
        check("err_sticky", flags_q[6], 1'b1);
`else
        check("err_nonsticky", flags_q[6], 1'b0);
`endif
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        cycle();
        check("err_cleared", flags_q[6], 1'b0);

        // Absolute op without sweep request: single write, no stall.
        drive(1, 5'd17, 5'd11, 32'h0, 32'h7777, 7'h00, 0, 0);
        cycle();
        check("abs_nosweep_addr", rf_waddr, 5'd11);
        check("abs_nosweep_data", rf_wdata, 32'h7777);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("abs_nosweep_stall", wb_stall, 1'b0);

        // Out-of-range clear base: the second instance writes once and never stalls.
        drive(1, 5'd14, 5'd9, 32'h0, 32'h4321, 7'h00, 1, 0);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("nosweep_we", n_rf_we, 1'b1);
        check("nosweep_waddr", n_rf_waddr, 5'd9);
        check("nosweep_wdata", n_rf_wdata, 32'h4321);
        check("nosweep_stall0", n_wb_stall, 1'b0);
        cmp_all();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("nosweep_stall1", n_wb_stall, 1'b0);
        while (m_stall) cycle();

        // Randomized traffic; a new instruction is offered only once the last one is taken.
        drive_random();
        for (int k = 0; k < 600; k++) begin
            cycle();
            if (k == 300) begin
                async_reset_check("traffic_reset");
                cycle();
                @(negedge clk);
                rst_n = 1'b1;
                drive_random();
            end else if (m_acc || !ex_valid) begin
                drive_random();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
